sc2110_i2c_wr_dri: RTL and testbench
====================================

// Module: sc2110_i2c_wr_dri
// PURPOSE
//  I2C write master for sensor register configuration. Consumes the {addr,data} word and the
//  exec pulse from the register-table sequencer; returns a one-cycle done pulse per register.
//  Drives SCL and open-drain SDA to the CMOS sensor. Sequence: START, slave-addr+W, reg-addr
//  (16 or 8 bit), data byte, STOP. Sits between the cfg sequencer and the sensor pins.
// PARAMETERS
//  SLAVE_ADDR  7'h30       7-bit sensor device address
//  CLK_FREQ    26'd50_000_000  clk frequency, Hz
//  I2C_FREQ    18'd250_000     SCL frequency, Hz
//  BIT_CTRL    1'b1        1: 16-bit reg addr (i2c_data[23:8]); 0: 8-bit (i2c_data[15:8])
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous reset, active low
//  i2c_exec    in   1   start pulse; sampled only when idle
//  i2c_data    in   24  {reg_addr[15:0], wr_data[7:0]}
//  i2c_done    out  1   one-cycle pulse, transfer finished (STOP sent)
//  i2c_busy    out  1   high from accepted exec until i2c_done
//  i2c_ack_err out  1   sticky NACK flag; cleared on next accepted exec
//  scl         out  1   I2C clock
//  sda         inout 1  I2C data, open drain (drive 0 or 1'bz)
// BEHAVIOUR
//  Interface: one clock (clk); rst_n asynchronous, active low.
//  Reset: scl=1, sda=z, i2c_done=0, i2c_busy=0, i2c_ack_err=0, FSM=IDLE, divider=0.
//  Divider: DIV=CLK_FREQ/(I2C_FREQ*4); tick pulses one clk every DIV clks (quarter SCL period);
//   counter free-runs only while busy, held at 0 in IDLE.
//  Each bit = 4 ticks: q0 scl=0 set SDA, q1 scl=1, q2 scl=1 sample SDA, q3 scl=0.
//  FSM: IDLE -> START -> SLADDR -> ADDR16 (BIT_CTRL=1 only) -> ADDR8 -> DATA -> STOP -> IDLE.
//   IDLE: i2c_exec=1 latches i2c_data, sets busy, clears ack_err, next START.
//   START: SDA 1->0 while SCL=1 (one bit period).
//   SLADDR: {SLAVE_ADDR,1'b0}; ADDR16: addr[15:8]; ADDR8: addr[7:0]; DATA: wr_data.
//   Each byte: 8 bits MSB first, 9th bit SDA released (z), sampled at q2.
//   STOP: SDA 0->1 while SCL=1; after q3 i2c_done=1 for one clk, busy=0, FSM=IDLE.
//  Latency exec->done: (2+9*N) bit periods, N=4 (BIT_CTRL=1) or 3; +/-1 tick.
//  i2c_exec while busy: ignored, no effect on latched data.
//  i2c_exec on same cycle done pulses: ignored (FSM not yet IDLE); accepted next cycle.
//  i2c_data changes after accept: no effect.
//  rst_n low mid-transfer: immediate return to reset values; no STOP generated.
// CONFIGURATION
//  SC2110_I2C_ACK_CHK_EN defined: SDA=1 at any ACK slot sets i2c_ack_err, FSM jumps to STOP
//   (remaining bytes skipped), i2c_done still pulses once.
//  Not defined: ACK slot sampled and ignored; i2c_ack_err tied 0; full sequence always sent.
// TESTING
//  1 exec, data=24'h0103_01, slave ACKs -> SDA bytes 0x60,0x01,0x03,0x01 framed START/STOP;
//    one done pulse; ack_err=0; SCL=250kHz at CLK_FREQ 50MHz (200 clk/period).
//  2 BIT_CTRL=0, data=24'h0012_A5 -> bytes 0x60,0x12,0xA5 only; done after 29 bit periods.
//  3 ACK_CHK_EN, slave NACKs byte 2 -> ack_err=1, STOP follows, bytes 3-4 absent, done once;
//    next exec clears ack_err. Without macro: all 4 bytes sent, ack_err=0.
//  4 exec pulses at cycles 10 and 500 (busy) -> only first transfer; second exec after done
//    with 24'h3e01_24 -> bytes 0x60,0x3E,0x01,0x24.
//  5 rst_n low during DATA byte -> scl=1, sda=z, busy=0 immediately, no done; next exec works.
//  6 112 back-to-back exec driven by done -> 112 done pulses, no lost/duplicated frames.

Source files
------------

// File: rtl/sc2110_i2c_wr_dri.sv
// sc2110_i2c_wr_dri: I2C write master for sensor register configuration.
// Frame: START, {SLAVE_ADDR,W}, reg addr (16 or 8 bit), data byte, STOP.
// Optional build macro: SC2110_I2C_ACK_CHK_EN. When it is defined, a NACK at any
// ACK slot sets i2c_ack_err and the frame is cut short with a STOP.
module sc2110_i2c_wr_dri #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h30,
    parameter logic [25:0] CLK_FREQ   = 26'd50_000_000,
    parameter logic [17:0] I2C_FREQ   = 18'd250_000,
    parameter logic        BIT_CTRL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_exec,
    input  logic [23:0] i2c_data,
    output logic        i2c_done,
    output logic        i2c_busy,
    output logic        i2c_ack_err,
    output logic        scl,
    inout  wire         sda
);

    // Quarter-SCL divider: I2C_FREQ is widened before the multiply so it cannot overflow.
    localparam int unsigned DIV_RAW = 32'(CLK_FREQ) / (32'(I2C_FREQ) * 32'd4);
    localparam int unsigned DIV     = (DIV_RAW == 32'd0) ? 32'd1 : DIV_RAW;
    localparam logic [25:0] DIV_M1  = 26'(DIV - 32'd1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SLADDR = 3'd2;
    localparam logic [2:0] S_ADDR16 = 3'd3;
    localparam logic [2:0] S_ADDR8  = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    logic [2:0]  state;
    logic [25:0] cnt;
    logic        tick;
    logic [1:0]  q;
    logic [3:0]  bit_idx;
    logic [7:0]  shreg;
    logic [23:0] data_lat;
    logic        busy;
    logic        done;
    logic        scl_q;
    logic        sda_low_q;
    logic        scl_nxt;
    logic        sda_low_nxt;
    logic [2:0]  nxt_state;
    logic [7:0]  nxt_byte;

    assign tick     = busy && (cnt == DIV_M1);
    assign i2c_busy = busy;
    assign i2c_done = done;
    assign scl      = scl_q;
    assign sda      = sda_low_q ? 1'b0 : 1'bz;

`ifdef SC2110_I2C_ACK_CHK_EN
    logic ack_err;
    logic nack_q;
    assign i2c_ack_err = ack_err;
`else
    assign i2c_ack_err = 1'b0;
`endif

    // Divider free-runs while busy, held at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!busy || tick)
            cnt <= '0;
        else
            cnt <= cnt + 26'd1;
    end

    // Byte sequencing: which state and byte follow the current byte's ACK slot.
    always_comb begin
        nxt_state = S_STOP;
        nxt_byte  = '0;
        case (state)
            S_SLADDR: begin
                if (BIT_CTRL) begin
                    nxt_state = S_ADDR16;
                    nxt_byte  = data_lat[23:16];
                end else begin
                    nxt_state = S_ADDR8;
                    nxt_byte  = data_lat[15:8];
                end
            end
            S_ADDR16: begin
                nxt_state = S_ADDR8;
                nxt_byte  = data_lat[15:8];
            end
            S_ADDR8: begin
                nxt_state = S_DATA;
                nxt_byte  = data_lat[7:0];
            end
            default: ;
        endcase
    end

    // Pin levels for the current quarter; idle levels whenever not busy.
    always_comb begin
        scl_nxt     = 1'b1;
        sda_low_nxt = 1'b0;
        if (busy) begin
            case (state)
                S_START: begin
                    scl_nxt     = (q != 2'd3);
                    sda_low_nxt = q[1];
                end
                S_SLADDR, S_ADDR16, S_ADDR8, S_DATA: begin
                    scl_nxt     = q[0] ^ q[1];
                    sda_low_nxt = (bit_idx != 4'd8) && !shreg[7];
                end
                S_STOP: begin
                    scl_nxt     = (q != 2'd0);
                    sda_low_nxt = !q[1];
                end
                default: ;
            endcase
        end
    end

    // Registered pin drivers so SCL/SDA are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            scl_q     <= scl_nxt;
            sda_low_q <= sda_low_nxt;
        end
    end

    // Transfer FSM. The done cycle keeps the FSM in STOP, so an exec arriving
    // with done is ignored and accepted on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            q        <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data_lat <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SC2110_I2C_ACK_CHK_EN
            ack_err  <= 1'b0;
            nack_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (i2c_exec) begin
                    data_lat <= i2c_data;
                    busy     <= 1'b1;
                    state    <= S_START;
                    q        <= '0;
                    bit_idx  <= '0;
`ifdef SC2110_I2C_ACK_CHK_EN
                    ack_err  <= 1'b0;
`endif
                end
            end else if (done) begin
                state <= S_IDLE;
            end else if (tick) begin
                q <= q + 2'd1;
`ifdef SC2110_I2C_ACK_CHK_EN
                if (q == 2'd2 && bit_idx == 4'd8)
                    nack_q <= sda;
`endif
                if (q == 2'd3) begin
                    case (state)
                        S_START: begin
                            state   <= S_SLADDR;
                            shreg   <= {SLAVE_ADDR, 1'b0};
                            bit_idx <= '0;
                        end
                        S_STOP: begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                        default: begin
                            if (bit_idx != 4'd8) begin
                                bit_idx <= bit_idx + 4'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                            end else begin
                                bit_idx <= '0;
                                state   <= nxt_state;
                                shreg   <= nxt_byte;
`ifdef SC2110_I2C_ACK_CHK_EN
                                if (nack_q) begin
                                    ack_err <= 1'b1;
                                    state   <= S_STOP;
                                end
`endif
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sc2110_i2c_wr_dri.sv
// Directed bench for sc2110_i2c_wr_dri: a 16-bit-address and an 8-bit-address
// instance, each with an open-drain bus slave that decodes START/STOP/bytes and ACKs.
module tb_sc2110_i2c_wr_dri;

    localparam int DIV   = 3;                    // 1200 / (100*4)
    localparam int LAT16 = 4 * DIV * (2 + 9*4);  // 456 clk
    localparam int LAT8  = 4 * DIV * (2 + 9*3);  // 348 clk

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  exec = '0;
    logic [23:0] data [2];
    wire  [1:0]  done, busy, err, scl;
    wire         sda16, sda8;
    logic [1:0]  slv_low = '0;

    pullup (sda16);
    pullup (sda8);
    assign sda16 = slv_low[0] ? 1'b0 : 1'bz;
    assign sda8  = slv_low[1] ? 1'b0 : 1'bz;
    wire [1:0] sda_v = {(sda8 === 1'b0) ? 1'b0 : 1'b1, (sda16 === 1'b0) ? 1'b0 : 1'b1};

    always #5 clk = ~clk;

    sc2110_i2c_wr_dri #(.SLAVE_ADDR(7'h30), .CLK_FREQ(26'd1200), .I2C_FREQ(18'd100), .BIT_CTRL(1'b1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .i2c_exec(exec[0]), .i2c_data(data[0]), .i2c_done(done[0]),
        .i2c_busy(busy[0]), .i2c_ack_err(err[0]), .scl(scl[0]), .sda(sda16));

    sc2110_i2c_wr_dri #(.SLAVE_ADDR(7'h30), .CLK_FREQ(26'd1200), .I2C_FREQ(18'd100), .BIT_CTRL(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i2c_exec(exec[1]), .i2c_data(data[1]), .i2c_done(done[1]),
        .i2c_busy(busy[1]), .i2c_ack_err(err[1]), .scl(scl[1]), .sda(sda8));

    int n_cmp = 0;
    int n_bad = 0;

    // Bus slave state
    int unsigned bitcnt [2];
    int unsigned fbyte [2];
    int unsigned nbytes [2];
    int unsigned starts [2];
    int unsigned stops [2];
    int          nack_at [2];
    logic [7:0]  sh [2];
    logic [7:0]  got [2][512];
    logic [1:0]  pscl = 2'b11;
    logic [1:0]  psda = 2'b11;

    // Slave: decode START/STOP, shift bits on SCL rise, ACK on SCL fall after 8 bits.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                slv_low[i] = 1'b0;
                bitcnt[i]  = 0;
            end else if (scl[i] && pscl[i] && psda[i] && !sda_v[i]) begin
                starts[i]++;
                bitcnt[i] = 0;
                fbyte[i]  = 0;
            end else if (scl[i] && pscl[i] && !psda[i] && sda_v[i]) begin
                stops[i]++;
            end else if (scl[i] && !pscl[i]) begin
                if (bitcnt[i] < 8) begin
                    sh[i] = {sh[i][6:0], sda_v[i]};
                    bitcnt[i]++;
                    if (bitcnt[i] == 8 && nbytes[i] < 512) begin
                        got[i][nbytes[i]] = sh[i];
                        nbytes[i]++;
                    end
                end else begin
                    bitcnt[i] = 0;
                    fbyte[i]++;
                end
            end else if (!scl[i] && pscl[i]) begin
                if (slv_low[i] && bitcnt[i] == 0)
                    slv_low[i] = 1'b0;
                if (bitcnt[i] == 8 && int'(fbyte[i]) != nack_at[i])
                    slv_low[i] = 1'b1;
            end
            pscl[i] = scl[i];
            psda[i] = sda_v[i];
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            nbytes[i] = 0; starts[i] = 0; stops[i] = 0; nack_at[i] = -1;
        end
    endtask

    // Call at a negedge; exec is sampled on the next posedge.
    task automatic kick(input int i, input logic [23:0] d);
        exec[i] = 1'b1;
        data[i] = d;
        @(negedge clk);
        exec[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int max, output int lat);
        lat = 0;
        while (done[i] !== 1'b1 && lat < max) begin
            @(negedge clk);
            lat++;
        end
        if (done[i] !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (scl[0] !== 1'b1) begin n_bad++; $display("FAIL rst_scl: got %b want 1", scl[0]); end
        n_cmp++; if (sda_v[0] !== 1'b1) begin n_bad++; $display("FAIL rst_sda: got %b want released", sda_v[0]); end
        n_cmp++; if (done[0] !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done[0]); end
        n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL rst_busy: got %b want 00", busy); end
        n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err[0]); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL idle_busy: got %b want 00", busy); end
    endtask

    task automatic test_frame16();
        logic [7:0] e [4] = '{8'h60, 8'h01, 8'h03, 8'h01};
        int lat;
        clear_mon();
        kick(0, 24'h0103_01);
        data[0] = 24'hFF_FFFF;
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL f16_busy: got %b want 1", busy[0]); end
        wait_done(0, 700, lat);
        n_cmp++; if (lat < LAT16 - DIV || lat > LAT16 + DIV) begin n_bad++; $display("FAIL f16_latency: got %0d want %0d", lat, LAT16); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL f16_busy_end: got %b want 0", busy[0]); end
        n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL f16_err: got %b want 0", err[0]); end
        @(negedge clk);
        n_cmp++; if (done[0] !== 1'b0) begin n_bad++; $display("FAIL f16_done_width: got %b want 0", done[0]); end
        n_cmp++; if (nbytes[0] != 4) begin n_bad++; $display("FAIL f16_nbytes: got %0d want 4", nbytes[0]); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got[0][k] !== e[k]) begin n_bad++; $display("FAIL f16_byte%0d: got %h want %h", k, got[0][k], e[k]); end
        end
        n_cmp++; if (starts[0] != 1 || stops[0] != 1) begin n_bad++; $display("FAIL f16_framing: got %0d/%0d want 1/1", starts[0], stops[0]); end
    endtask

    task automatic test_scl_period();
        int t = 0;
        int lat;
        logic p;
        kick(0, 24'h5555_AA);
        p = scl[0];
        while (!(!p && scl[0]) && t < 100) begin p = scl[0]; @(negedge clk); t++; end
        t = 0;
        p = scl[0];
        @(negedge clk); t++;
        while (!(!p && scl[0]) && t < 100) begin p = scl[0]; @(negedge clk); t++; end
        n_cmp++; if (t != 4 * DIV) begin n_bad++; $display("FAIL scl_period: got %0d want %0d", t, 4 * DIV); end
        wait_done(0, 700, lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL scl_done_timeout: got %0d want done", lat); end
        @(negedge clk);
    endtask

    task automatic test_addr8();
        logic [7:0] e [3] = '{8'h60, 8'h12, 8'hA5};
        int lat;
        clear_mon();
        kick(1, 24'h0012_A5);
        wait_done(1, 600, lat);
        n_cmp++; if (lat < LAT8 - DIV || lat > LAT8 + DIV) begin n_bad++; $display("FAIL a8_latency: got %0d want %0d", lat, LAT8); end
        @(negedge clk);
        n_cmp++; if (nbytes[1] != 3) begin n_bad++; $display("FAIL a8_nbytes: got %0d want 3", nbytes[1]); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (got[1][k] !== e[k]) begin n_bad++; $display("FAIL a8_byte%0d: got %h want %h", k, got[1][k], e[k]); end
        end
        n_cmp++; if (stops[1] != 1) begin n_bad++; $display("FAIL a8_stop: got %0d want 1", stops[1]); end
    endtask

    task automatic test_nack();
        int lat;
        int unsigned exp_n;
        logic exp_err;
`ifdef SC2110_I2C_ACK_CHK_EN
        exp_n = 2; exp_err = 1'b1;
`else
        exp_n = 4; exp_err = 1'b0;
`endif
        clear_mon();
        nack_at[0] = 1;
        kick(0, 24'h0103_01);
        wait_done(0, 700, lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL nack_timeout: got %0d want done", lat); end
        n_cmp++; if (err[0] !== exp_err) begin n_bad++; $display("FAIL nack_err: got %b want %b", err[0], exp_err); end
        @(negedge clk);
        n_cmp++; if (done[0] !== 1'b0) begin n_bad++; $display("FAIL nack_done_once: got %b want 0", done[0]); end
        n_cmp++; if (nbytes[0] != exp_n) begin n_bad++; $display("FAIL nack_nbytes: got %0d want %0d", nbytes[0], exp_n); end
        n_cmp++; if (stops[0] != 1) begin n_bad++; $display("FAIL nack_stop: got %0d want 1", stops[0]); end
        nack_at[0] = -1;
        kick(0, 24'h0103_01);
        n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL nack_clear: got %b want 0", err[0]); end
        wait_done(0, 700, lat);
        @(negedge clk);
    endtask

    task automatic test_exec_busy();
        logic [7:0] e1 [4] = '{8'h60, 8'h12, 8'h34, 8'h56};
        logic [7:0] e2 [4] = '{8'h60, 8'h3E, 8'h01, 8'h24};
        int lat;
        clear_mon();
        kick(0, 24'h1234_56);
        repeat (190) @(negedge clk);
        kick(0, 24'h9999_99);
        wait_done(0, 700, lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL busy_timeout: got %0d want done", lat); end
        // exec raised exactly during the done cycle must be ignored
        exec[0] = 1'b1; data[0] = 24'h7777_77;
        @(negedge clk);
        exec[0] = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL done_cycle_exec: got busy %b want 0", busy[0]); end
        n_cmp++; if (starts[0] != 1) begin n_bad++; $display("FAIL busy_starts: got %0d want 1", starts[0]); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got[0][k] !== e1[k]) begin n_bad++; $display("FAIL busy_byte%0d: got %h want %h", k, got[0][k], e1[k]); end
        end
        clear_mon();
        kick(0, 24'h3E01_24);
        wait_done(0, 700, lat);
        @(negedge clk);
        n_cmp++; if (nbytes[0] != 4) begin n_bad++; $display("FAIL next_nbytes: got %0d want 4", nbytes[0]); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got[0][k] !== e2[k]) begin n_bad++; $display("FAIL next_byte%0d: got %h want %h", k, got[0][k], e2[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e [4] = '{8'h60, 8'hAB, 8'hCD, 8'hEF};
        int seen = 0;
        int lat;
        clear_mon();
        kick(0, 24'h0103_01);
        repeat (349) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (scl[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_scl: got %b want 1", scl[0]); end
        n_cmp++; if (sda_v[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_sda: got %b want released", sda_v[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy[0]); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d want 0", seen); end
        clear_mon();
        kick(0, 24'hABCD_EF);
        wait_done(0, 700, lat);
        @(negedge clk);
        n_cmp++; if (nbytes[0] != 4) begin n_bad++; $display("FAIL rmid_nbytes: got %0d want 4", nbytes[0]); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got[0][k] !== e[k]) begin n_bad++; $display("FAIL rmid_byte%0d: got %h want %h", k, got[0][k], e[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int ndone = 0;
        int bad_lat = 0;
        int bad_byte = 0;
        logic [7:0] kb;
        clear_mon();
        kick(1, 24'h0000_FF);
        for (int k = 0; k < 112; k++) begin
            wait_done(1, 600, lat);
            if (lat < 0) break;
            ndone++;
            if (lat < LAT8 - DIV || lat > LAT8 + DIV) bad_lat++;
            if (k < 111) begin
                kb = 8'(k + 1);
                exec[1] = 1'b1;
                data[1] = {8'h00, kb, ~kb};
                repeat (2) @(negedge clk);
                exec[1] = 1'b0;
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (ndone != 112) begin n_bad++; $display("FAIL b2b_done: got %0d want 112", ndone); end
        n_cmp++; if (starts[1] != 112 || stops[1] != 112) begin n_bad++; $display("FAIL b2b_framing: got %0d/%0d want 112/112", starts[1], stops[1]); end
        n_cmp++; if (bad_lat != 0) begin n_bad++; $display("FAIL b2b_latency: got %0d bad frames want 0", bad_lat); end
        n_cmp++; if (nbytes[1] != 336) begin n_bad++; $display("FAIL b2b_nbytes: got %0d want 336", nbytes[1]); end
        for (int k = 0; k < 112; k++) begin
            kb = 8'(k);
            if (got[1][3*k] !== 8'h60 || got[1][3*k+1] !== kb || got[1][3*k+2] !== ~kb) bad_byte++;
        end
        n_cmp++; if (bad_byte != 0) begin n_bad++; $display("FAIL b2b_bytes: got %0d bad frames want 0", bad_byte); end
    endtask

    initial begin
        data[0] = '0;
        data[1] = '0;
        clear_mon();
        for (int i = 0; i < 2; i++) begin bitcnt[i] = 0; fbyte[i] = 0; sh[i] = '0; end
        @(negedge clk);
        test_reset();
        test_frame16();
        test_scl_period();
        test_addr8();
        test_nack();
        test_exec_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1);
    end

endmodule
